// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle run-control sequencer for the Y86-64 SEQ core.
// Holds the registered PC and steps each instruction through
// FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD. It also tracks the
// Y86 status code and supports single-step and data-memory wait states.
// Optional feature macro: SEQ_CTRL_PERF_CNT_EN enables the cycle and
// retired-instruction counters. When it is undefined, both counters read 0.

module seq_ctrl #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32),
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic              clear,
  input  logic [3:0]        icode,
  input  logic              instr_valid,
  input  logic              imem_error,
  input  logic              mem_ready,
  input  logic              dmem_error,
  input  logic [ADDR_W-1:0] updated_pc,
  output logic [ADDR_W-1:0] PC,
  output logic              fetch_en,
  output logic              decode_en,
  output logic              exec_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic              pc_we,
  output logic [2:0]        stat,
  output logic              running,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instr_count
);

  // Y86 status codes
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // The halt instruction's icode
  localparam logic [3:0] ICODE_HALT = 4'h0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    PCUPD     = 3'd6,
    HALT      = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        stat_q, stat_d;

  // State, PC and status registers. Reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      stat_q  <= STAT_AOK;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
    end
  end

  // Next-state logic. The PC moves only at PCUPD or on clear from HALT, and
  // stays on the faulting instruction when a fault sends us to HALT.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        if (imem_error) begin
          state_d = HALT;
          stat_d  = STAT_ADR;
        end else if (!instr_valid) begin
          state_d = HALT;
          stat_d  = STAT_INS;
        end else if (icode == ICODE_HALT) begin
          state_d = HALT;
          stat_d  = STAT_HLT;
        end else begin
          state_d = DECODE;
        end
      end
      DECODE:  state_d = EXECUTE;
      EXECUTE: state_d = MEMORY;
      MEMORY: begin
        if (mem_ready) begin
          if (dmem_error) begin
            state_d = HALT;
            stat_d  = STAT_ADR;
          end else begin
            state_d = WRITEBACK;
          end
        end
      end
      WRITEBACK: state_d = PCUPD;
      PCUPD: begin
        pc_d    = updated_pc;
        state_d = step ? IDLE : FETCH;
      end
      HALT: begin
        if (clear) begin
          state_d = IDLE;
          pc_d    = RESET_PC;
          stat_d  = STAT_AOK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded purely from the state register, so they cannot glitch on inputs.
  always_comb begin
    fetch_en  = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    mem_en    = 1'b0;
    wb_en     = 1'b0;
    pc_we     = 1'b0;
    running   = 1'b1;
    halted    = 1'b0;
    unique case (state_q)
      IDLE:      running   = 1'b0;
      FETCH:     fetch_en  = 1'b1;
      DECODE:    decode_en = 1'b1;
      EXECUTE:   exec_en   = 1'b1;
      MEMORY:    mem_en    = 1'b1;
      WRITEBACK: wb_en     = 1'b1;
      PCUPD:     pc_we     = 1'b1;
      HALT: begin
        running = 1'b0;
        halted  = 1'b1;
      end
      default:   running   = 1'b0;
    endcase
  end

  assign PC   = pc_q;
  assign stat = stat_q;

`ifdef SEQ_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instr_q;

  // Performance counters: active cycles (wait states and the faulting cycle included) and retired instructions.
  // Both wrap naturally, and clear does not reset them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (running)          cycle_q <= cycle_q + CNT_W'(1);
      if (state_q == PCUPD) instr_q <= instr_q + CNT_W'(1);
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Multi-cycle run-control sequencer for the Y86-64 SEQ processor. It replaces free-running clock toggling and combinational PC feedback with a registered PC and a phase state machine. The state machine steps each instruction through fetch, decode, execute, memory, writeback and PC update. It also tracks the Y86 status code, supports single-step and memory wait states, and sits between the top-level bench/core and the existing fetch, register file, execute, memory and PC-update stages.

## Interface
Parameters:
- ADDR_W, 64, PC / address width
- RESET_PC, 64'd32, PC value after reset or clear
- CNT_W, 32, width of performance counters

Ports (clk, rst_n; reset is asynchronous and active-low; single clock domain):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  leave IDLE and begin/resume execution
- step  input  1  single-step mode; sampled in PCUPD
- clear  input  1  leave HALT; restore RESET_PC and AOK
- icode  input  4  from fetch
- instr_valid  input  1  from fetch
- imem_error  input  1  from fetch
- mem_ready  input  1  data memory access complete
- dmem_error  input  1  data memory address error
- updated_pc  input  ADDR_W  from pc_update
- PC  output  ADDR_W  registered program counter
- fetch_en, decode_en, exec_en, mem_en, wb_en  output  1 each  one-hot phase enables
- pc_we  output  1  high during PCUPD
- stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- running  output  1  state not IDLE and not HALT
- halted  output  1  state == HALT
- cycle_count  output  CNT_W  active cycles
- instr_count  output  CNT_W  retired instructions

## Operation
States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.

Reset values (rst_n low, immediately):
- state IDLE
- PC = RESET_PC
- stat = 1
- enables, pc_we, running, halted = 0
- counters = 0

Transitions:
- IDLE -> FETCH when start = 1; otherwise hold.
- FETCH: checks in priority order:
  - imem_error -> HALT, stat = 3
  - else instr_valid = 0 -> HALT, stat = 4
  - else icode = 4'h0 -> HALT, stat = 2
  - else -> DECODE
- DECODE -> EXECUTE -> MEMORY, unconditionally.
- MEMORY:
  - holds while mem_ready = 0
  - mem_ready = 1 and dmem_error = 1 -> HALT, stat = 3
  - mem_ready = 1 and dmem_error = 0 -> WRITEBACK
- WRITEBACK -> PCUPD.
- PCUPD:
  - PC <= updated_pc
  - instr_count++
  - then -> IDLE if step = 1, else -> FETCH
- HALT: holds; PC keeps the address of the faulting/halt instruction.
  - clear = 1 -> IDLE, PC = RESET_PC, stat = 1.
  - start is ignored in HALT, including when asserted together with clear.

Output behaviour:
- Enables are Moore outputs decoded from the state register: exactly one is high in FETCH..WRITEBACK, none elsewhere.
- pc_we is high only in PCUPD.
- PC changes only in PCUPD, on clear, or on reset.
- cycle_count increments on every clock edge where running = 1. It covers wait states and includes the final FETCH/MEMORY cycle that enters HALT.
- Both counters wrap modulo 2^CNT_W and are not reset by clear.

## Timing
- Minimum instruction latency: 6 cycles (FETCH through PCUPD). Throughput is 1 instruction per 6 cycles with mem_ready tied high.
- Each MEMORY wait adds exactly 1 cycle per mem_ready = 0 sample.
- Inputs are sampled at the rising edge ending the relevant state. Upstream stages must settle icode, instr_valid, imem_error and updated_pc within the enabling phase.
- Fault detection is 1 cycle: HALT, the new stat and halted are visible the cycle after the faulting FETCH/MEMORY edge.
- start in IDLE: FETCH begins on the next edge; start level is irrelevant once running.
- Reset asserted mid-instruction aborts it: no PC update, no count.
- step toggled mid-instruction takes effect only at that instruction's PCUPD.

## Configuration
- SEQ_CTRL_PERF_CNT_EN defined: cycle_count and instr_count are implemented as described.
- SEQ_CTRL_PERF_CNT_EN undefined: no counter registers; cycle_count and instr_count are tied to 0. All other behaviour is identical.

## Test plan
- Reset, start = 1, mem_ready = 1, three valid non-halt instructions at PC 32/42/52 (updated_pc = PC + 10), then icode 0 -> 18 cycles plus 1 FETCH; stat = 2; halted = 1; PC = 62; instr_count = 3; cycle_count = 19.
- step = 1, start pulsed once -> exactly one instruction retires, return to IDLE, PC 32 -> 42, instr_count = 1; a second start pulse retires the next instruction.
- mem_ready low for 4 cycles in MEMORY -> mem_en high 5 cycles; latency = 10 cycles; no enable glitches.
- instr_valid = 0 at PC 32 -> HALT, stat = 4, PC = 32; then clear with start both high -> IDLE, PC = 32, stat = 1, next cycle still IDLE.
- dmem_error with mem_ready in MEMORY -> HALT, stat = 3, no pc_we pulse, instr_count unchanged.
- rst_n dropped asynchronously during EXECUTE -> outputs reach reset values before the next clk edge; with macro undefined, counters read 0 throughout.
